// File: rtl/chunked_addsub.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock, carry rippled
// between chunks through a register, results returned on a start/done handshake.
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             carryout_q, carryout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [KW-1:0]    k_q, k_d;

  logic [CHUNK-1:0] x_chunk;
  logic [CHUNK-1:0] y_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic [CHUNK:0]   c_chain;
  logic             last_chunk;

  assign x_chunk    = op_a_q[k_q*CHUNK +: CHUNK];
  assign y_chunk    = op_b_q[k_q*CHUNK +: CHUNK];
  assign c_chain[0] = carry_q;
  assign last_chunk = (k_q == KW'(N - 1));

  // One chunk-wide ripple slice; the carry register closes the loop between passes.
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    assign s_chunk[gi]   = x_chunk[gi] ^ y_chunk[gi] ^ c_chain[gi];
    assign c_chain[gi+1] = (x_chunk[gi] & y_chunk[gi]) |
                           (x_chunk[gi] & c_chain[gi]) |
                           (y_chunk[gi] & c_chain[gi]);
  end

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    carryout_d = carryout_q;
    ovf_d      = ovf_q;
    k_d        = k_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[k_q*CHUNK +: CHUNK] = s_chunk;
        carry_d = c_chain[CHUNK];
        k_d     = k_q + 1'b1;
        if (last_chunk) begin
          // c_chain[CHUNK-1] is the carry into the result's MSB.
          sum_d      = acc_d;
          carryout_d = c_chain[CHUNK];
          ovf_d      = c_chain[CHUNK] ^ c_chain[CHUNK-1];
          done_d     = 1'b1;
          k_d        = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      carryout_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      carryout_q <= carryout_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      k_q        <= k_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign sum      = sum_q;
  assign carryout = carryout_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub: directed tests on CHUNK=4, random sweep
// over CHUNK = 1, 4 and 16 with WIDTH = 16.
module tb_chunked_addsub;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start4, start16;
  logic        sub, cin;
  logic [15:0] a, b;
  logic        busy1, busy4, busy16;
  logic        done1, done4, done16;
  logic [15:0] sum1, sum4, sum16;
  logic        co1, co4, co16;
  logic        ov1, ov4, ov16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chunked_addsub #(.WIDTH(16), .CHUNK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy1), .done(done1), .sum(sum1), .carryout(co1), .ovf(ov1));
  chunked_addsub #(.WIDTH(16), .CHUNK(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy4), .done(done4), .sum(sum4), .carryout(co4), .ovf(ov4));
  chunked_addsub #(.WIDTH(16), .CHUNK(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy16), .done(done16), .sum(sum16), .carryout(co16), .ovf(ov16));

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic s, input logic c, input int t0);
    exp_t        e;
    logic [15:0] yy;
    logic [16:0] full;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + 17'(s ? 1'b1 : c);
    e.s  = full[15:0];
    e.co = full[16];
    e.ov = (x[15] == yy[15]) && (full[15] != x[15]);
    e.t0 = t0;
    return e;
  endfunction

  // Scoreboard monitors: pop one expectation per done pulse.
  initial begin : mon4
    exp_t e;
    forever begin
      @(negedge clk);
      if (done4) begin
        checks++;
        if (busy4 !== 1'b0) begin errors++; $display("FAIL u4_done_with_busy busy=%b required 0", busy4); end
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL u4_unexpected_done at cycle %0d required no done", cyc);
        end else begin
          e = q4.pop_front();
          checks += 4;
          if (sum4 !== e.s)  begin errors++; $display("FAIL u4_sum got %h required %h", sum4, e.s); end
          if (co4 !== e.co)  begin errors++; $display("FAIL u4_carryout got %b required %b", co4, e.co); end
          if (ov4 !== e.ov)  begin errors++; $display("FAIL u4_ovf got %b required %b", ov4, e.ov); end
          if (cyc - e.t0 !== 4) begin errors++; $display("FAIL u4_latency got %0d required 4", cyc - e.t0); end
          $display("u4  sum=%h co=%b ov=%b latency=%0d", sum4, co4, ov4, cyc - e.t0);
        end
      end
    end
  end

  initial begin : mon1
    exp_t e;
    forever begin
      @(negedge clk);
      if (done1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL u1_unexpected_done at cycle %0d required no done", cyc);
        end else begin
          e = q1.pop_front();
          checks += 4;
          if (sum1 !== e.s)  begin errors++; $display("FAIL u1_sum got %h required %h", sum1, e.s); end
          if (co1 !== e.co)  begin errors++; $display("FAIL u1_carryout got %b required %b", co1, e.co); end
          if (ov1 !== e.ov)  begin errors++; $display("FAIL u1_ovf got %b required %b", ov1, e.ov); end
          if (cyc - e.t0 !== 16) begin errors++; $display("FAIL u1_latency got %0d required 16", cyc - e.t0); end
        end
      end
    end
  end

  initial begin : mon16
    exp_t e;
    forever begin
      @(negedge clk);
      if (done16) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL u16_unexpected_done at cycle %0d required no done", cyc);
        end else begin
          e = q16.pop_front();
          checks += 4;
          if (sum16 !== e.s)  begin errors++; $display("FAIL u16_sum got %h required %h", sum16, e.s); end
          if (co16 !== e.co)  begin errors++; $display("FAIL u16_carryout got %b required %b", co16, e.co); end
          if (ov16 !== e.ov)  begin errors++; $display("FAIL u16_ovf got %b required %b", ov16, e.ov); end
          if (cyc - e.t0 !== 1) begin errors++; $display("FAIL u16_latency got %0d required 1", cyc - e.t0); end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue4(input logic [15:0] x, input logic [15:0] y, input logic s, input logic c);
    a = x; b = y; sub = s; cin = c;
    start4 = 1'b1;
    q4.push_back(model(x, y, s, c, cyc + 1));
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_all_idle(input int budget);
    int n = 0;
    while ((busy1 || busy4 || busy16) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy1 || busy4 || busy16) begin
      errors++;
      $display("FAIL idle_timeout busy=%b%b%b required 000", busy1, busy4, busy16);
    end
  endtask

  task automatic test_reset;
    checks += 3;
    if ({busy4, done4, co4, ov4} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b required 0000", {busy4, done4, co4, ov4});
    end
    if (sum4 !== 16'h0) begin errors++; $display("FAIL reset_sum got %h required 0000", sum4); end
    if ({busy1, busy16, done1, done16, sum1, sum16} !== 36'h0) begin
      errors++; $display("FAIL reset_sweep_insts got %h required 0", {busy1, busy16, done1, done16, sum1, sum16});
    end
    $display("reset checked busy=%b done=%b sum=%h", busy4, done4, sum4);
  endtask

  task automatic test_add;
    issue4(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    checks++;
    if (busy4 !== 1'b1) begin errors++; $display("FAIL add_busy_rise got %b required 1", busy4); end
    wait_all_idle(20);
    @(negedge clk);
    issue4(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_all_idle(20);
    @(negedge clk);
    issue4(16'h1234, 16'h1111, 1'b0, 1'b1);
    wait_all_idle(20);
    @(negedge clk);
  endtask

  task automatic test_sub;
    issue4(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_all_idle(20);
    @(negedge clk);
    issue4(16'h8000, 16'h0001, 1'b1, 1'b0);
    wait_all_idle(20);
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    issue4(16'h1111, 16'h2222, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      checks += 2;
      if (busy4 !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b required 1", busy4); end
      if (sum4 !== 16'h7FFF) begin errors++; $display("FAIL ignore_sum_hold got %h required 7fff", sum4); end
      start4 = (j % 2 == 0);
      a = 16'($urandom);
      b = 16'($urandom);
      sub = 1'($urandom);
      @(negedge clk);
    end
    start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1) begin errors++; $display("FAIL ignore_busy_last got %b required 1", busy4); end
    wait_all_idle(20);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n = 0;
    issue4(16'h00FF, 16'h0001, 1'b0, 1'b0);
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done4 !== 1'b1) begin
      errors++; $display("FAIL b2b_done_timeout got %b required 1", done4);
    end else begin
      issue4(16'h1000, 16'h0001, 1'b1, 1'b0);
      checks++;
      if (busy4 !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b required 1", busy4); end
    end
    wait_all_idle(20);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    issue4(16'hABCD, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    q4.delete();
    #1;
    checks += 2;
    if ({busy4, done4, co4, ov4} !== 4'b0) begin
      errors++; $display("FAIL midrst_flags got %b required 0000", {busy4, done4, co4, ov4});
    end
    if (sum4 !== 16'h0) begin errors++; $display("FAIL midrst_sum got %h required 0000", sum4); end
    $display("mid-operation reset sum=%h busy=%b", sum4, busy4);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checks++;
      if (done4 !== 1'b0 || busy4 !== 1'b0) begin
        errors++; $display("FAIL midrst_quiet done=%b busy=%b required 0 0", done4, busy4);
      end
    end
    issue4(16'h4000, 16'h4000, 1'b0, 1'b0);
    wait_all_idle(20);
    @(negedge clk);
  endtask

  task automatic test_sweep;
    exp_t e;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      sub = 1'($urandom);
      cin = 1'($urandom);
      e = model(a, b, sub, cin, cyc + 1);
      q1.push_back(e);
      q4.push_back(e);
      q16.push_back(e);
      start1 = 1'b1; start4 = 1'b1; start16 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0; start16 = 1'b0;
      wait_all_idle(40);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q1.size() + q4.size() + q16.size() !== 0) begin
      errors++; $display("FAIL sweep_drain pending=%0d required 0", q1.size() + q4.size() + q16.size());
    end
    $display("sweep complete 1000 vectors per instance");
  endtask

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0; start4 = 1'b0; start16 = 1'b0;
    sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_add;
    test_sub;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunked_addsub.md
# chunked_addsub

Parametrised, multi-cycle two's-complement adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry between chunks in a register. Results come back through a start/done handshake with carry-out and signed-overflow flags. It succeeds the team's 4-bit combinational adder for wide datapaths where a full-width ripple chain would not close timing.

## Interface
- WIDTH, 16: operand/result width in bits; must be a positive multiple of CHUNK.
- CHUNK, 4: bits added per clock; CHUNK == WIDTH gives single-pass operation.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy == 0.
- sub  input  1  0: add; 1: subtract (a - b).
- cin  input  1  carry-in, used in add mode only.
- a  input  WIDTH  operand X.
- b  input  WIDTH  operand Y.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result outputs valid from this cycle.
- sum  output  WIDTH  result.
- carryout  output  1  carry out of bit WIDTH-1. In subtract mode this is the raw carry, so 1 means no borrow.
- ovf  output  1  signed overflow = C[WIDTH] ^ C[WIDTH-1].

## Operation
- N = WIDTH/CHUNK passes.
- States are IDLE and RUN.
- IDLE, start == 1 at an edge:
  - Latch the operands: opA = a; opB = sub ? ~b : b.
  - Set the carry register to sub ? 1 : cin.
  - Set chunk index k = 0.
  - Go to RUN and set busy = 1.
- RUN, each edge processes chunk k, bits [k*CHUNK +: CHUNK]:
  - Each bit i: s = x ^ y ^ c; c_next = (x&y) | (x&c) | (y&c).
  - Write the chunk into the internal accumulator.
  - Carry register gets the chunk's top carry.
  - Retain the carry into the chunk's top bit as c_msb_in.
  - k increments.
- Last chunk (k == N-1) edge:
  - Copy the accumulator plus that chunk into sum.
  - carryout = final carry; ovf = final carry ^ c_msb_in.
  - done = 1 for the following cycle; busy = 0; return to IDLE.
- sum, carryout and ovf change only at completion. They hold their values otherwise, including throughout RUN.
- Operand inputs are don't-care after the start edge; the block uses its latched copies.
- start while busy == 1 is ignored. It is not queued and does not disturb the operation in flight.
- start in the done cycle (busy == 0) is accepted, giving back-to-back operation.
- Subtract: a + ~b + 1 over WIDTH bits, with cin ignored. ovf uses the same rule as add.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, busy = 0, done = 0, sum = 0, carryout = 0, ovf = 0; internal carry, index and operand registers cleared.
- Reset mid-operation aborts the operation immediately.
  - No done pulse.
  - Outputs go to their reset values.
  - After rst_n rises, the block waits in IDLE for a new start.
- Start accepted at edge E0:
  - busy rises after E0.
  - Chunks are processed at edges E1 through EN.
  - done is high and the results are valid in the cycle after EN.
  - Latency is N cycles from the start edge to done; throughput is one operation per N cycles.
- CHUNK == WIDTH: N = 1, done is high one cycle after the start edge, and busy is high for one cycle.
- done never asserts with busy == 1. done is never high for more than one consecutive cycle unless back-to-back starts occur with N == 1.

## Test plan
- WIDTH=16, CHUNK=4; add a=0x7FFF, b=0x0001, cin=0 -> sum 0x8000, carryout 0, ovf 1, done exactly 4 cycles after the start edge.
- Add a=0xFFFF, b=0x0001, cin=0 -> sum 0x0000, carryout 1, ovf 0. Then add a=0x1234, b=0x1111, cin=1 -> sum 0x2346, carryout 0, ovf 0.
- Subtract a=0x0005, b=0x0007, cin=1 -> sum 0xFFFE, carryout 0, ovf 0, proving cin is ignored. Subtract a=0x8000, b=0x0001 -> sum 0x7FFF, carryout 1, ovf 1.
- Pulse start with new operands twice during busy, and change a/b mid-operation -> the first result is unaffected and no extra done appears. Assert start in the done cycle -> the second operation completes 4 cycles later.
- Drop rst_n at the second RUN cycle -> all outputs are 0 immediately and no done follows. A fresh start after release completes normally.
- Parameter sweep CHUNK ∈ {1, 4, 16} with WIDTH=16: random 1000 vectors checked against a behavioural a±b model (sum, carryout, ovf); latency equals WIDTH/CHUNK in each case.
